dual_elevator_top: RTL and testbench



---
 rtl/dual_elevator_top.sv | 181 ++++++++++++++++++
 tb/tb_dual_elevator_top.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_elevator_top.sv
// Two-car, four-floor elevator controller: latches hall requests, sends each one to the
// nearer idle car, and sequences the cars through move/door phases with emergency freeze.
// Optional build macro ELEV_EMERGENCY_DOOR_OPEN_EN: idle/door cars show open doors in emergency.
module dual_elevator_top #(
  parameter int unsigned FLOOR_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] floor_requests,
  input  logic       emergency_stop,
  input  logic [1:0] priority_floor,
  input  logic       priority_request,
  output logic [1:0] elev1_current_floor,
  output logic [1:0] elev2_current_floor,
  output logic       elev1_door_open,
  output logic       elev2_door_open,
  output logic       elev1_moving_up,
  output logic       elev2_moving_up,
  output logic       elev1_moving_down,
  output logic       elev2_moving_down,
  output logic       elev1_busy,
  output logic       elev2_busy,
  output logic [3:0] request_ack,
  output logic       emergency_override
);
  localparam int unsigned CNT_MAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;

  state_t           r_state   [2];
  logic [1:0]       r_floor   [2];
  logic [1:0]       r_target  [2];
  logic             r_has_tgt [2];
  logic [CNT_W-1:0] r_cnt     [2];
  logic [3:0]       r_pending;
  logic [3:0]       r_assigned;

  logic             w_emerg;
  logic [3:0]       w_cand;
  logic             w_cand_vld;
  logic [1:0]       w_cand_floor;
  logic [1:0]       w_free;
  logic [1:0]       w_dist       [2];
  logic [1:0]       w_next_floor [2];
  logic [1:0]       w_up;
  logic [1:0]       w_down;
  logic [1:0]       w_door;
  logic             w_disp_vld;
  logic             w_disp_car;
  logic [3:0]       w_set;
  logic [3:0]       w_clear;
  logic [3:0]       w_assign;

  assign w_emerg = emergency_stop;

  // Candidate floor: priority floor first when enabled, else the lowest pending unassigned floor
  always_comb begin
    w_cand       = r_pending & ~r_assigned;
    w_cand_vld   = 1'b0;
    w_cand_floor = 2'd0;
    if (priority_request && w_cand[priority_floor]) begin
      w_cand_vld   = 1'b1;
      w_cand_floor = priority_floor;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (w_cand[i]) begin
          w_cand_vld   = 1'b1;
          w_cand_floor = 2'(i);
        end
      end
    end
  end

  // Per-car decode: availability, distance to candidate, next floor, status outputs, service clear
  always_comb begin
    w_clear = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      w_free[c]       = (r_state[c] == ST_IDLE) && !r_has_tgt[c];
      w_dist[c]       = (r_floor[c] >= w_cand_floor) ? (r_floor[c] - w_cand_floor)
                                                     : (w_cand_floor - r_floor[c]);
      w_next_floor[c] = (r_target[c] > r_floor[c]) ? (r_floor[c] + 2'd1) : (r_floor[c] - 2'd1);
      w_up[c]         = (r_state[c] == ST_MOVE) && (r_target[c] > r_floor[c]) && !w_emerg;
      w_down[c]       = (r_state[c] == ST_MOVE) && (r_target[c] < r_floor[c]) && !w_emerg;
`ifdef ELEV_EMERGENCY_DOOR_OPEN_EN
      w_door[c]       = (r_state[c] == ST_DOOR) || (w_emerg && (r_state[c] == ST_IDLE));
`else
      w_door[c]       = (r_state[c] == ST_DOOR);
`endif
      if ((r_state[c] == ST_DOOR) && (r_cnt[c] == DOOR_LAST) && !w_emerg) begin
        w_clear[r_target[c]] = 1'b1;
      end
    end
  end

  // Dispatch to the nearer idle car (tie to elev1); emergency blocks both latching and dispatch
  always_comb begin
    w_disp_vld = !w_emerg && w_cand_vld && (w_free != 2'b00);
    w_disp_car = 1'b0;
    if (w_free == 2'b11) begin
      w_disp_car = (w_dist[1] < w_dist[0]);
    end else begin
      w_disp_car = w_free[1];
    end
    w_assign = w_disp_vld ? (4'b0001 << w_cand_floor) : 4'b0000;
    w_set    = 4'b0000;
    if (!w_emerg) begin
      w_set = priority_request ? (4'b0001 << priority_floor) : floor_requests;
    end
  end

  // Request bookkeeping and car FSMs; everything holds while the emergency stop is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 4'b0000;
      r_assigned <= 4'b0000;
      for (int c = 0; c < 2; c++) begin
        r_state[c]   <= ST_IDLE;
        r_target[c]  <= 2'd0;
        r_has_tgt[c] <= 1'b0;
        r_cnt[c]     <= '0;
      end
      r_floor[0] <= 2'd0;
      r_floor[1] <= 2'd3;
    end else if (!w_emerg) begin
      r_pending  <= (r_pending & ~w_clear) | w_set;
      r_assigned <= (r_assigned & ~w_clear) | w_assign;
      for (int c = 0; c < 2; c++) begin
        case (r_state[c])
          ST_IDLE: begin
            r_cnt[c] <= '0;
            if (r_has_tgt[c]) begin
              r_state[c] <= (r_target[c] == r_floor[c]) ? ST_DOOR : ST_MOVE;
            end else if (w_disp_vld && (w_disp_car == 1'(c))) begin
              r_target[c]  <= w_cand_floor;
              r_has_tgt[c] <= 1'b1;
            end
          end
          ST_MOVE: begin
            if (r_cnt[c] == FLOOR_LAST) begin
              r_cnt[c]   <= '0;
              r_floor[c] <= w_next_floor[c];
              if (w_next_floor[c] == r_target[c]) begin
                r_state[c] <= ST_DOOR;
              end
            end else begin
              r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
          end
          ST_DOOR: begin
            if (r_cnt[c] == DOOR_LAST) begin
              r_cnt[c]     <= '0;
              r_state[c]   <= ST_IDLE;
              r_has_tgt[c] <= 1'b0;
            end else begin
              r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
          end
          default: r_state[c] <= ST_IDLE;
        endcase
      end
    end
  end

  assign elev1_current_floor = r_floor[0];
  assign elev2_current_floor = r_floor[1];
  assign elev1_door_open     = w_door[0];
  assign elev2_door_open     = w_door[1];
  assign elev1_moving_up     = w_up[0];
  assign elev2_moving_up     = w_up[1];
  assign elev1_moving_down   = w_down[0];
  assign elev2_moving_down   = w_down[1];
  assign elev1_busy          = (r_state[0] != ST_IDLE);
  assign elev2_busy          = (r_state[1] != ST_IDLE);
  assign request_ack         = r_pending;
  assign emergency_override  = w_emerg;

endmodule

// File: tb/tb_dual_elevator_top.sv
// Directed bench for dual_elevator_top; service events (car, floor) are scoreboarded against
// the expected service order pushed when each request is driven.
module tb_dual_elevator_top;
  logic       clk;
  logic       rst;
  logic [3:0] floor_requests;
  logic       emergency_stop;
  logic [1:0] priority_floor;
  logic       priority_request;
  logic [1:0] elev1_current_floor;
  logic [1:0] elev2_current_floor;
  logic       elev1_door_open;
  logic       elev2_door_open;
  logic       elev1_moving_up;
  logic       elev2_moving_up;
  logic       elev1_moving_down;
  logic       elev2_moving_down;
  logic       elev1_busy;
  logic       elev2_busy;
  logic [3:0] request_ack;
  logic       emergency_override;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] svc_exp[$];
  logic [7:0] svc_act[$];
  logic d1_prev = 1'b0;
  logic d2_prev = 1'b0;

  dual_elevator_top dut (
    .clk                 (clk),
    .rst                 (rst),
    .floor_requests      (floor_requests),
    .emergency_stop      (emergency_stop),
    .priority_floor      (priority_floor),
    .priority_request    (priority_request),
    .elev1_current_floor (elev1_current_floor),
    .elev2_current_floor (elev2_current_floor),
    .elev1_door_open     (elev1_door_open),
    .elev2_door_open     (elev2_door_open),
    .elev1_moving_up     (elev1_moving_up),
    .elev2_moving_up     (elev2_moving_up),
    .elev1_moving_down   (elev1_moving_down),
    .elev2_moving_down   (elev2_moving_down),
    .elev1_busy          (elev1_busy),
    .elev2_busy          (elev2_busy),
    .request_ack         (request_ack),
    .emergency_override  (emergency_override)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each door opening as a service event {car, floor}
  always @(posedge clk) begin
    #2;
    if (!emergency_override && elev1_door_open && !d1_prev)
      svc_act.push_back({4'd1, 2'b00, elev1_current_floor});
    if (!emergency_override && elev2_door_open && !d2_prev)
      svc_act.push_back({4'd2, 2'b00, elev2_current_floor});
    d1_prev = elev1_door_open;
    d2_prev = elev2_door_open;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_service(input string tag);
    logic [7:0] e;
    logic [7:0] a;
    while (svc_exp.size() > 0) begin
      e = svc_exp.pop_front();
      a = (svc_act.size() > 0) ? svc_act.pop_front() : 8'hFF;
      chk(tag, a, e);
    end
    chk({tag, "_extra"}, 8'(svc_act.size()), 8'd0);
    svc_act.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    floor_requests = 4'b0000;
    priority_request = 1'b0;
    priority_floor = 2'd0;
    emergency_stop = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    svc_act.delete();
    svc_exp.delete();
  endtask

  initial begin
    logic [7:0] door_emerg_exp;
`ifdef ELEV_EMERGENCY_DOOR_OPEN_EN
    door_emerg_exp = 8'd1;
`else
    door_emerg_exp = 8'd0;
`endif
    rst = 1'b1;
    floor_requests = 4'b0000;
    priority_request = 1'b0;
    priority_floor = 2'd0;
    emergency_stop = 1'b1;
    #1;
    chk("ovr_in_reset", 8'(emergency_override), 8'd1);
    emergency_stop = 1'b0;
    #1;
    chk("ovr_in_reset_off", 8'(emergency_override), 8'd0);

    // Reset values
    do_reset();
    chk("rst_floor1", 8'(elev1_current_floor), 8'd0);
    chk("rst_floor2", 8'(elev2_current_floor), 8'd3);
    chk("rst_ack", 8'(request_ack), 8'h00);
    chk("rst_busy", 8'({elev1_busy, elev2_busy}), 8'd0);
    chk("rst_door", 8'({elev1_door_open, elev2_door_open}), 8'd0);

    // Nearest dispatch: floor 2 goes to elev2 (distance 1 vs 2)
    floor_requests = 4'b0100; svc_exp.push_back(8'h22);
    step(1); floor_requests = 4'b0000;
    chk("nd_ack", 8'(request_ack), 8'h04);
    step(1);
    chk("nd_busy2_dispatch", 8'(elev2_busy), 8'd0);
    step(1);
    chk("nd_busy2", 8'(elev2_busy), 8'd1);
    chk("nd_down2", 8'(elev2_moving_down), 8'd1);
    chk("nd_up2", 8'(elev2_moving_up), 8'd0);
    step(7);
    chk("nd_floor2_mid", 8'(elev2_current_floor), 8'd3);
    chk("nd_busy1", 8'(elev1_busy), 8'd0);
    step(1);
    chk("nd_floor2_arr", 8'(elev2_current_floor), 8'd2);
    chk("nd_door2", 8'(elev2_door_open), 8'd1);
    chk("nd_down2_arr", 8'(elev2_moving_down), 8'd0);
    step(3);
    chk("nd_door2_last", 8'(elev2_door_open), 8'd1);
    chk("nd_ack_held", 8'(request_ack), 8'h04);
    step(1);
    chk("nd_door2_closed", 8'(elev2_door_open), 8'd0);
    chk("nd_ack_clear", 8'(request_ack), 8'h00);
    chk("nd_floor1", 8'(elev1_current_floor), 8'd0);
    check_service("nd_svc");

    // Two requests: floor 2 to elev2 first, then floor 3 to the remaining idle car (elev1)
    do_reset();
    floor_requests = 4'b1100; svc_exp.push_back(8'h22); svc_exp.push_back(8'h13);
    step(1); floor_requests = 4'b0000;
    chk("tr_ack", 8'(request_ack), 8'h0C);
    step(2);
    chk("tr_down2", 8'(elev2_moving_down), 8'd1);
    chk("tr_busy1_wait", 8'(elev1_busy), 8'd0);
    step(1);
    chk("tr_up1", 8'(elev1_moving_up), 8'd1);
    step(11);
    chk("tr_ack_after2", 8'(request_ack), 8'h08);
    chk("tr_floor2", 8'(elev2_current_floor), 8'd2);
    step(5);
    chk("tr_floor1_mid", 8'(elev1_current_floor), 8'd2);
    step(8);
    chk("tr_floor1_arr", 8'(elev1_current_floor), 8'd3);
    chk("tr_door1", 8'(elev1_door_open), 8'd1);
    step(4);
    chk("tr_ack_clear", 8'(request_ack), 8'h00);
    check_service("tr_svc");

    // Priority mode: only the priority floor latches
    do_reset();
    priority_request = 1'b1; priority_floor = 2'd2; floor_requests = 4'b0101;
    svc_exp.push_back(8'h22);
    step(1);
    chk("pr_ack0", 8'(request_ack), 8'h04);
    step(1);
    chk("pr_ack1", 8'(request_ack), 8'h04);
    step(1);
    chk("pr_ack2", 8'(request_ack), 8'h04);
    priority_request = 1'b0; floor_requests = 4'b0000;
    step(8);
    chk("pr_door2", 8'(elev2_door_open), 8'd1);
    chk("pr_ack_arr", 8'(request_ack), 8'h04);
    step(4);
    chk("pr_ack_clear", 8'(request_ack), 8'h00);
    check_service("pr_svc");

    // Emergency mid-travel freezes elev2 and blocks new requests
    do_reset();
    floor_requests = 4'b0100; svc_exp.push_back(8'h22);
    step(1); floor_requests = 4'b0000;
    step(5);
    chk("em_down_before", 8'(elev2_moving_down), 8'd1);
    emergency_stop = 1'b1; floor_requests = 4'b1111;
    #1;
    chk("em_ovr", 8'(emergency_override), 8'd1);
    chk("em_down_now", 8'(elev2_moving_down), 8'd0);
    step(5);
    chk("em_floor2", 8'(elev2_current_floor), 8'd3);
    chk("em_ack", 8'(request_ack), 8'h04);
    chk("em_busy2", 8'(elev2_busy), 8'd1);
    chk("em_moving", 8'({elev1_moving_up, elev1_moving_down, elev2_moving_up, elev2_moving_down}), 8'd0);
    chk("em_door2", 8'(elev2_door_open), 8'd0);
    chk("em_door1", 8'(elev1_door_open), door_emerg_exp);
    floor_requests = 4'b0000; emergency_stop = 1'b0;
    #1;
    chk("em_ovr_off", 8'(emergency_override), 8'd0);
    chk("em_down_resume", 8'(elev2_moving_down), 8'd1);
    step(4);
    chk("em_floor2_resume", 8'(elev2_current_floor), 8'd3);
    step(1);
    chk("em_floor2_arr", 8'(elev2_current_floor), 8'd2);
    chk("em_door2_arr", 8'(elev2_door_open), 8'd1);
    step(4);
    chk("em_ack_clear", 8'(request_ack), 8'h00);
    check_service("em_svc");

    // Sequential requests 3, 2, 1, 0 spaced 20 cycles apart
    do_reset();
    floor_requests = 4'b1000; svc_exp.push_back(8'h23);
    step(1); floor_requests = 4'b0000;
    step(2);
    chk("sq_door2_f3", 8'(elev2_door_open), 8'd1);
    step(17);
    floor_requests = 4'b0100; svc_exp.push_back(8'h22);
    step(1); floor_requests = 4'b0000;
    step(19);
    chk("sq_ack_f2", 8'(request_ack), 8'h00);
    chk("sq_floor2", 8'(elev2_current_floor), 8'd2);
    floor_requests = 4'b0010; svc_exp.push_back(8'h11);
    step(1); floor_requests = 4'b0000;
    step(2);
    chk("sq_up1_tie", 8'(elev1_moving_up), 8'd1);
    step(17);
    chk("sq_floor1", 8'(elev1_current_floor), 8'd1);
    floor_requests = 4'b0001; svc_exp.push_back(8'h10);
    step(1); floor_requests = 4'b0000;
    step(2);
    chk("sq_down1", 8'(elev1_moving_down), 8'd1);
    step(12);
    chk("sq_ack_done", 8'(request_ack), 8'h00);
    chk("sq_busy1_done", 8'(elev1_busy), 8'd0);
    step(10);
    check_service("sq_svc");

    // Reset mid-move aborts everything asynchronously
    floor_requests = 4'b0010;
    step(1); floor_requests = 4'b0000;
    step(5);
    chk("ra_up1", 8'(elev1_moving_up), 8'd1);
    rst = 1'b1;
    #1;
    chk("ra_busy", 8'({elev1_busy, elev2_busy}), 8'd0);
    chk("ra_moving", 8'({elev1_moving_up, elev1_moving_down, elev2_moving_up, elev2_moving_down}), 8'd0);
    chk("ra_floor1", 8'(elev1_current_floor), 8'd0);
    chk("ra_floor2", 8'(elev2_current_floor), 8'd3);
    chk("ra_ack", 8'(request_ack), 8'h00);
    step(1);
    rst = 1'b0;
    step(3);
    chk("ra_busy_after", 8'({elev1_busy, elev2_busy}), 8'd0);
    chk("ra_svc_none", 8'(svc_act.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
